// File: rtl/cpu_core_8bit.sv
// cpu_core_8bit
//   Minimal accumulator CPU that masters an 8-bit memory bus. Code is fetched
//   from ROM (0x80-0xFF), data lives in RAM (0x00-0x7F). Every instruction is
//   two bytes (opcode, operand) and takes three cycles:
//   FETCH_OP -> FETCH_ARG -> EXEC. HLT parks the core in HALT until reset.
//
// Ports
//   clk           in   1  system clock, all state changes on posedge
//   rst           in   1  synchronous reset, active-high
//   address_bus   out  8  memory address (PC while fetching/halted, ARG in EXEC)
//   write_enable  out  1  memory write strobe, high only in EXEC of STA
//   from_cpu      out  8  write data, always the accumulator
//   to_cpu        in   8  read data, combinational from address_bus
//   halted        out  1  high while in HALT
//   acc_out       out  8  accumulator, for visibility
//   state_o       out  2  current FSM state (debug)
//
// Handshake: the bus has no valid/ready; the memory answers to_cpu in the same
// cycle as address_bus and commits a write at the posedge ending a cycle in
// which write_enable is high.

module cpu_core_8bit #(
    parameter logic [7:0] RESET_PC = 8'h80
) (
    input  logic       clk,
    input  logic       rst,
    output logic [7:0] address_bus,
    output logic       write_enable,
    output logic [7:0] from_cpu,
    input  logic [7:0] to_cpu,
    output logic       halted,
    output logic [7:0] acc_out,
    output logic [1:0] state_o
);

    typedef enum logic [1:0] {
        S_FETCH_OP  = 2'd0,
        S_FETCH_ARG = 2'd1,
        S_EXEC      = 2'd2,
        S_HALT      = 2'd3
    } state_t;

    localparam logic [7:0] OP_NOP = 8'h00;
    localparam logic [7:0] OP_LDI = 8'h01;
    localparam logic [7:0] OP_LDA = 8'h02;
    localparam logic [7:0] OP_STA = 8'h03;
    localparam logic [7:0] OP_ADD = 8'h04;
    localparam logic [7:0] OP_SUB = 8'h05;
    localparam logic [7:0] OP_JMP = 8'h06;
    localparam logic [7:0] OP_JZ  = 8'h07;
    localparam logic [7:0] OP_JC  = 8'h08;
    localparam logic [7:0] OP_HLT = 8'hFF;

    state_t     state_q, state_d;
    logic [7:0] pc_q, pc_d;
    logic [7:0] ir_q, ir_d;
    logic [7:0] arg_q, arg_d;
    logic [7:0] a_q, a_d;
    logic       z_q, z_d;
    logic       c_q, c_d;

    logic [8:0] sum9;
    logic [7:0] bus_addr;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FETCH_OP;
            pc_q    <= RESET_PC;
            ir_q    <= 8'h00;
            arg_q   <= 8'h00;
            a_q     <= 8'h00;
            z_q     <= 1'b0;
            c_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            arg_q   <= arg_d;
            a_q     <= a_d;
            z_q     <= z_d;
            c_q     <= c_d;
        end
    end

    // Next-state and datapath. In EXEC, to_cpu is M = memory[ARG].
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        arg_d   = arg_q;
        a_d     = a_q;
        z_d     = z_q;
        c_d     = c_q;
        sum9    = 9'd0;

        case (state_q)
            S_FETCH_OP: begin
                ir_d    = to_cpu;
                pc_d    = pc_q + 8'd1;
                state_d = S_FETCH_ARG;
            end
            S_FETCH_ARG: begin
                arg_d   = to_cpu;
                pc_d    = pc_q + 8'd1;
                state_d = S_EXEC;
            end
            S_EXEC: begin
                state_d = S_FETCH_OP;
                case (ir_q)
                    OP_LDI: begin
                        a_d = arg_q;
                        z_d = (arg_q == 8'h00);
                    end
                    OP_LDA: begin
                        a_d = to_cpu;
                        z_d = (to_cpu == 8'h00);
                    end
                    OP_ADD: begin
                        sum9 = {1'b0, a_q} + {1'b0, to_cpu};
                        a_d  = sum9[7:0];
                        c_d  = sum9[8];
                        z_d  = (sum9[7:0] == 8'h00);
                    end
                    OP_SUB: begin
                        // The 9th bit of the two's-complement difference is the borrow.
                        sum9 = {1'b0, a_q} - {1'b0, to_cpu};
                        a_d  = sum9[7:0];
                        c_d  = sum9[8];
                        z_d  = (sum9[7:0] == 8'h00);
                    end
                    OP_JMP: pc_d = arg_q;
                    OP_JZ:  if (z_q) pc_d = arg_q;
                    OP_JC:  if (c_q) pc_d = arg_q;
                    OP_HLT: state_d = S_HALT;
                    // STA only drives the bus; NOP and unknown opcodes do nothing.
                    OP_NOP, OP_STA: ;
                    default: ;
                endcase
            end
            S_HALT: ;
            default: state_d = S_FETCH_OP;
        endcase
    end

    // Bus outputs depend only on registered state (and rst), never on to_cpu.
    always_comb begin
        bus_addr = (state_q == S_EXEC) ? arg_q : pc_q;
    end

    assign address_bus  = rst ? RESET_PC : bus_addr;
    assign write_enable = !rst && (state_q == S_EXEC) && (ir_q == OP_STA);
    assign from_cpu     = a_q;
    assign halted       = !rst && (state_q == S_HALT);
    assign acc_out      = rst ? 8'h00 : a_q;
    assign state_o      = state_q;

endmodule
